// File: rtl/memory_access_pkg.sv
// Shared types for the memory-access pipeline stage: stage payload, memory
// instruction fields, access sizes and the stage FSM encoding.
package memory_access_pkg;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'd0,
        MEM_HALF = 2'd1,
        MEM_WORD = 2'd2
    } mem_size_t;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } mem_state_t;

    typedef struct packed {
        logic      mem_read;
        logic      mem_write;
        mem_size_t mem_size;
        logic      mem_unsigned;
    } instr_t;

    // Result bundle: address is the destination register (rd), data is the
    // execute result (effective address for memory instructions).
    typedef struct packed {
        logic        valid;
        logic [4:0]  address;
        logic [31:0] data;
    } reg_data_t;

    typedef struct packed {
        logic        valid;
        logic        ready;
        instr_t      instr;
        reg_data_t   data;
        logic [31:0] reg_rd2;
    } stage_status_t;

    localparam int WAIT_CNT_W = 8;

    function automatic logic is_mem(input instr_t i);
        return i.mem_read | i.mem_write;
    endfunction

endpackage

// File: rtl/memory_access_align.sv
// Byte-lane steering for stores, misalignment detection, and load lane
// extraction with sign/zero extension. Purely combinational.
module load_store_align
    import memory_access_pkg::*;
(
    input  logic [1:0]  req_offset,
    input  mem_size_t   req_size,
    input  logic        req_store,
    input  logic [31:0] req_wdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic        misaligned,
    input  logic [1:0]  rsp_offset,
    input  mem_size_t   rsp_size,
    input  logic        rsp_unsigned,
    input  logic [31:0] rdata,
    output logic [31:0] load_data
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    // Request side: loads read the full word (be = 1111) and pick the lane on
    // return; stores enable only the lanes they write.
    always_comb begin
        be         = 4'b1111;
        wdata      = req_wdata;
        misaligned = 1'b0;
        case (req_size)
            MEM_BYTE: begin
                wdata = {4{req_wdata[7:0]}};
                if (req_store) be = 4'b0001 << req_offset;
            end
            MEM_HALF: begin
                wdata      = {2{req_wdata[15:0]}};
                misaligned = req_offset[0];
                if (req_store) be = 4'b0011 << {req_offset[1], 1'b0};
            end
            default: begin
                misaligned = |req_offset;
            end
        endcase
    end

    // Response side: select the addressed lane and extend it to 32 bits.
    always_comb begin
        case (rsp_offset)
            2'd0:    rd_byte = rdata[7:0];
            2'd1:    rd_byte = rdata[15:8];
            2'd2:    rd_byte = rdata[23:16];
            default: rd_byte = rdata[31:24];
        endcase
        rd_half = rsp_offset[1] ? rdata[31:16] : rdata[15:0];
        case (rsp_size)
            MEM_BYTE: load_data = rsp_unsigned ? {24'b0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
            MEM_HALF: load_data = rsp_unsigned ? {16'b0, rd_half} : {{16{rd_half[15]}}, rd_half};
            default:  load_data = rdata;
        endcase
    end

endmodule

// File: rtl/memory_access.sv
// Memory-access pipeline stage. Non-memory instructions pass through in one
// cycle; loads/stores run a req/ack bus transaction and stall upstream.
//
// Handshake: stage_out.ready is high only in IDLE (a function of state alone).
// An instruction is taken on any rising edge where stage_in.valid is high and
// ready is high; upstream holds stage_in stable while ready is low.
// The bus request mem_req rises on the accept edge and stays high until the
// edge on which mem_ack is sampled high (or the wait is abandoned).
module memory_access
    import memory_access_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int MAX_WAIT   = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  stage_status_t         stage_in,
    output stage_status_t         stage_out,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [3:0]            mem_be,
    input  logic                  mem_ack,
    input  logic [31:0]           mem_rdata,
    output logic                  misaligned,
    output logic                  bus_timeout
);

    mem_state_t            state_q, state_d;
    stage_status_t         out_q;
    stage_status_t         hold_q;
    logic [WAIT_CNT_W-1:0] wait_cnt_q;

    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic        req_misaligned;
    logic [31:0] load_data;
    logic        in_mem;
    logic        accept;
    logic        timeout_hit;

    // Control bits that are carried along but intentionally never read.
    logic unused_bits;
    assign unused_bits = ^{stage_in.ready, hold_q.valid, hold_q.ready, hold_q.data.valid, out_q.ready};

    load_store_align u_align (
        .req_offset   (stage_in.data.data[1:0]),
        .req_size     (stage_in.instr.mem_size),
        .req_store    (stage_in.instr.mem_write),
        .req_wdata    (stage_in.reg_rd2),
        .be           (req_be),
        .wdata        (req_wdata),
        .misaligned   (req_misaligned),
        .rsp_offset   (hold_q.data.data[1:0]),
        .rsp_size     (hold_q.instr.mem_size),
        .rsp_unsigned (hold_q.instr.mem_unsigned),
        .rdata        (mem_rdata),
        .load_data    (load_data)
    );

    assign in_mem = stage_in.valid && is_mem(stage_in.instr);
    assign accept = (state_q == IDLE) && in_mem && !req_misaligned;
    // The wait counter holds the number of ack-less wait edges seen so far;
    // the edge that would make it MAX_WAIT abandons the transaction.
    assign timeout_hit = (state_q == WAIT_ACK) && !mem_ack && (MAX_WAIT != 0) &&
                         ((32'(wait_cnt_q) + 32'd1) >= 32'(MAX_WAIT));

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (accept) state_d = WAIT_ACK;
            WAIT_ACK: if (mem_ack || timeout_hit) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // FSM outputs: registered payload with ready taken from the current state.
    always_comb begin
        stage_out       = out_q;
        stage_out.ready = (state_q == IDLE);
    end

    // Datapath: output register, transaction latch, bus drive and pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q       <= '0;
            hold_q      <= '0;
            wait_cnt_q  <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_be      <= '0;
            misaligned  <= 1'b0;
            bus_timeout <= 1'b0;
        end else begin
            misaligned  <= 1'b0;
            bus_timeout <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!stage_in.valid) begin
                        out_q.valid <= 1'b0;
                    end else if (!in_mem) begin
                        out_q <= stage_in;
                    end else if (req_misaligned) begin
                        out_q            <= stage_in;
                        out_q.valid      <= 1'b1;
                        out_q.data.valid <= 1'b0;
                        misaligned       <= 1'b1;
                    end else begin
                        hold_q      <= stage_in;
                        out_q.valid <= 1'b0;
                        mem_req     <= 1'b1;
                        mem_we      <= stage_in.instr.mem_write;
                        mem_be      <= req_be;
                        mem_wdata   <= req_wdata;
                        mem_addr    <= ADDR_WIDTH'({stage_in.data.data[31:2], 2'b00});
                        wait_cnt_q  <= '0;
                    end
                end
                WAIT_ACK: begin
                    if (mem_ack) begin
                        mem_req     <= 1'b0;
                        out_q       <= hold_q;
                        out_q.valid <= 1'b1;
                        if (hold_q.instr.mem_write) begin
                            out_q.data.valid <= 1'b0;
                        end else begin
                            out_q.data.data  <= load_data;
                            out_q.data.valid <= 1'b1;
                        end
                    end else if (timeout_hit) begin
                        mem_req          <= 1'b0;
                        bus_timeout      <= 1'b1;
                        out_q            <= hold_q;
                        out_q.valid      <= 1'b1;
                        out_q.data.valid <= 1'b0;
                    end else if (wait_cnt_q != {WAIT_CNT_W{1'b1}}) begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                default: begin
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
